step_pulse_shaper: RTL and testbench

//  Downstream of the speed integrator. Takes its one-cycle step/dir strobes and drives the

---
 rtl/step_pulse_shaper.sv | 169 ++++++++++++++++
 tb/tb_step_pulse_shaper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper: turns one-cycle step/dir strobes into STEP/DIR pin waveforms
// with programmable DIR setup and STEP high/low widths. A small direction FIFO
// absorbs bursts; a dropped step sets a sticky overflow flag.
// Optional feature macro: STEP_SHAPER_POS_EN builds the signed absolute
// position counter. Without it, position is tied to 0.
module step_pulse_shaper #(
  parameter int PULSE_BITS = 8,
  parameter int FIFO_BITS  = 3,
  parameter int POS_BITS   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step_in,
  input  logic                       dir_in,
  input  logic [PULSE_BITS-1:0]      pulse_len,
  input  logic [PULSE_BITS-1:0]      dir_setup,
  input  logic                       clr_overflow,
  input  logic                       set_pos,
  input  logic signed [POS_BITS-1:0] pos_val,
  output logic                       step_out,
  output logic                       dir_out,
  output logic                       busy,
  output logic [FIFO_BITS:0]         pending,
  output logic                       overflow,
  output logic signed [POS_BITS-1:0] position
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] FULL_CNT = DEPTH[FIFO_BITS:0];

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t                state, state_nx;
  logic [PULSE_BITS-1:0] timer, timer_nx;
  logic                  step_nx, dir_nx;

  logic [DEPTH-1:0]      fifo_mem;
  logic [FIFO_BITS-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_BITS:0]    count;
  logic                  fifo_empty, fifo_full, head, pop, push, drop;

  // A zero-length field still yields a one-cycle phase.
  function automatic logic [PULSE_BITS-1:0] phase_load(input logic [PULSE_BITS-1:0] field);
    return (field == '0) ? '0 : field - 1'b1;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign head       = fifo_mem[rd_ptr];
  // The FSM only consumes entries while idle.
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push       = step_in && (!fifo_full || pop);
  assign drop       = step_in && fifo_full && !pop;

  // Direction FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dir_in;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  // Pulse FSM next-state: timing fields are sampled only when the timer loads.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    step_nx  = step_out;
    dir_nx   = dir_out;
    case (state)
      IDLE: begin
        if (pop) begin
          if (head == dir_out) begin
            step_nx  = 1'b1;
            timer_nx = phase_load(pulse_len);
            state_nx = HIGH;
          end else begin
            dir_nx   = head;
            timer_nx = phase_load(dir_setup);
            state_nx = SETUP;
          end
        end
      end
      SETUP: begin
        if (timer == '0) begin
          step_nx  = 1'b1;
          timer_nx = phase_load(pulse_len);
          state_nx = HIGH;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      HIGH: begin
        if (timer == '0) begin
          step_nx  = 1'b0;
          timer_nx = phase_load(pulse_len);
          state_nx = LOW;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      LOW: begin
        if (timer == '0) state_nx = IDLE;
        else             timer_nx = timer - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pulse FSM registers, including the STEP/DIR pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      step_out <= 1'b0;
      dir_out  <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      step_out <= step_nx;
      dir_out  <= dir_nx;
    end
  end

  assign pending = count;
  assign busy    = (state != IDLE) || !fifo_empty;

`ifdef STEP_SHAPER_POS_EN
  logic step_rise;
  // dir_out is already settled when STEP rises, so it gives the count direction.
  assign step_rise = step_nx & ~step_out;

  // Absolute position: a load takes priority over a coincident step edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         position <= '0;
    else if (set_pos)   position <= pos_val;
    else if (step_rise) position <= dir_out ? position - 1'b1 : position + 1'b1;
  end
`else
  logic unused_pos;
  assign unused_pos = ^{set_pos, pos_val};
  assign position   = '0;
`endif

  // DIR must hold through SETUP, HIGH and LOW.
  a_dir_stable: assert property (@(posedge clk) disable iff (!reset)
    (state != IDLE) |=> $stable(dir_out));

endmodule

// File: tb/tb_step_pulse_shaper.sv
// Bench for step_pulse_shaper: table-driven single-step vectors, hand sequences for
// bursts/overflow/reset/position load, and random traffic against a schedule model.
module tb_step_pulse_shaper;

`ifdef STEP_SHAPER_POS_EN
  localparam bit POS_EN = 1'b1;
`else
  localparam bit POS_EN = 1'b0;
`endif
  localparam longint BIG = 64'h7fff_ffff_ffff;

  logic clk = 1'b0;
  logic reset, step_in, dir_in, clr_overflow, set_pos;
  logic [7:0] pulse_len, dir_setup;
  logic signed [31:0] pos_val;
  logic step_out, dir_out, busy, overflow;
  logic [3:0] pending;
  logic signed [31:0] position;

  always #5 clk = ~clk;

  step_pulse_shaper dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .pulse_len(pulse_len), .dir_setup(dir_setup), .clr_overflow(clr_overflow),
    .set_pos(set_pos), .pos_val(pos_val), .step_out(step_out), .dir_out(dir_out),
    .busy(busy), .pending(pending), .overflow(overflow), .position(position)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each popped step is a schedule of absolute cycle numbers.
  longint cyc, m_rise, m_fall, m_end;
  bit m_dir, m_ovf;
  bit mq[$];
  logic signed [31:0] m_pos;

  function automatic longint mx1(input logic [7:0] f);
    return (f == 8'd0) ? 64'd1 : longint'(f);
  endfunction

  task automatic model_reset();
    cyc = 0; m_rise = BIG; m_fall = BIG; m_end = 0;
    m_dir = 0; m_ovf = 0; mq.delete(); m_pos = 0;
  endtask

  task automatic model_step();
    longint c;
    bit pop, full, drop, d;
    if (!reset) begin model_reset(); return; end
    c = cyc;
    pop = (c >= m_end) && (mq.size() != 0);
    full = (mq.size() == 8);
    drop = step_in && full && !pop;
    if (pop) begin
      d = mq.pop_front();
      m_fall = BIG; m_end = BIG;
      if (d != m_dir) begin m_dir = d; m_rise = c + 1 + mx1(dir_setup); end
      else m_rise = c + 1;
    end
    if (step_in && !drop) mq.push_back(dir_in);
    if (drop) m_ovf = 1;
    else if (clr_overflow) m_ovf = 0;
    if (c + 1 == m_rise) m_fall = m_rise + mx1(pulse_len);
    if (c + 1 == m_fall) m_end = m_fall + mx1(pulse_len);
    if (POS_EN) begin
      if (set_pos) m_pos = pos_val;
      else if (c + 1 == m_rise) m_pos = m_dir ? m_pos - 1 : m_pos + 1;
    end
    cyc = c + 1;
  endtask

  task automatic check_model();
    logic e_step, e_busy;
    e_step = (cyc >= m_rise) && (cyc < m_fall);
    e_busy = (cyc < m_end) || (mq.size() != 0);
    n_vec++;
    if (step_out !== e_step || dir_out !== m_dir || busy !== e_busy ||
        pending !== 4'(mq.size()) || overflow !== m_ovf || position !== m_pos) begin
      n_err++;
      $display("FAIL model cyc=%0d got step=%b dir=%b busy=%b pend=%0d ovf=%b pos=%0d expected step=%b dir=%b busy=%b pend=%0d ovf=%b pos=%0d",
               cyc, step_out, dir_out, busy, pending, overflow, position,
               e_step, m_dir, e_busy, mq.size(), m_ovf, m_pos);
    end
  endtask

  // One clock: model advances at the edge, outputs compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (busy && k < lim) begin tick(); k++; end
    chk("idle_timeout", busy, 0);
  endtask

  typedef struct {
    logic [7:0] pl, ds;
    logic d;
    int tdir, rise, fall, idle, pd;
  } vec_t;
  vec_t vt[8];

  initial begin
    logic signed [31:0] p0;
    int t_dir, t_rise, t_fall, t_idle, peak, pulses, nr;
    int rise_at[4];
    bit prev, hit;

    // pulse_len, dir_setup, dir, first cycle dir_out==dir, rise, fall, idle, pos delta
    vt[0] = '{8'd3,   8'd2,   1'b0, 1, 2,   5,   8,   1};
    vt[1] = '{8'd3,   8'd2,   1'b1, 2, 4,   7,   10, -1};
    vt[2] = '{8'd0,   8'd0,   1'b1, 1, 2,   3,   4,  -1};
    vt[3] = '{8'd1,   8'd5,   1'b0, 2, 7,   8,   9,   1};
    vt[4] = '{8'd2,   8'd0,   1'b1, 2, 3,   5,   7,  -1};
    vt[5] = '{8'd255, 8'd1,   1'b1, 1, 2,   257, 512,-1};
    vt[6] = '{8'd5,   8'd255, 1'b0, 2, 257, 262, 267, 1};
    vt[7] = '{8'd4,   8'd3,   1'b1, 2, 5,   9,   13, -1};

    reset = 0; step_in = 0; dir_in = 0; clr_overflow = 0; set_pos = 0;
    pos_val = 0; pulse_len = 0; dir_setup = 0;
    model_reset();
    repeat (3) tick();
    chk("reset_pending", pending, 0);
    reset = 1;
    tick();

    // Single-step vectors from idle
    for (int i = 0; i < 8; i++) begin
      pulse_len = vt[i].pl; dir_setup = vt[i].ds;
      p0 = position;
      dir_in = vt[i].d; step_in = 1;
      t_dir = -1; t_rise = -1; t_fall = -1; t_idle = -1;
      for (int k = 1; k <= 600 && t_idle < 0; k++) begin
        tick();
        step_in = 0;
        if (t_dir < 0 && dir_out == vt[i].d) t_dir = k;
        if (t_rise < 0 && step_out) t_rise = k;
        if (t_rise >= 0 && t_fall < 0 && !step_out) t_fall = k;
        if (!busy) t_idle = k;
      end
      chk($sformatf("v%0d_dir_cycle", i), t_dir, vt[i].tdir);
      chk($sformatf("v%0d_rise", i), t_rise, vt[i].rise);
      chk($sformatf("v%0d_fall", i), t_fall, vt[i].fall);
      chk($sformatf("v%0d_idle", i), t_idle, vt[i].idle);
      chk($sformatf("v%0d_pos_delta", i), position - p0, POS_EN ? vt[i].pd : 0);
    end

    // Four back-to-back zero-width steps with a direction change first
    pulse_len = 0; dir_setup = 0; peak = 0; nr = 0; prev = step_out; p0 = position;
    for (int k = 0; k < 30; k++) begin
      step_in = (k < 4); dir_in = 0;
      tick();
      if (pending > peak) peak = pending;
      if (step_out && !prev && nr < 4) begin rise_at[nr] = k + 1; nr++; end
      prev = step_out;
    end
    chk("burst_pulses", nr, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("burst_rise%0d", j), rise_at[j], 3 + 3 * j);
    chk("burst_peak_pending", peak, 3);
    chk("burst_pos_delta", position - p0, POS_EN ? 4 : 0);

    // Overflow: twelve steps into a depth-8 FIFO while a long pulse runs
    pulse_len = 10; peak = 0; pulses = 0; prev = step_out;
    for (int k = 0; k < 400; k++) begin
      step_in = (k < 12); dir_in = 0;
      tick();
      if (pending > peak) peak = pending;
      if (step_out && !prev) pulses++;
      prev = step_out;
      if (k >= 12 && !busy) break;
    end
    step_in = 0;
    chk("ovf_peak_pending", peak, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_pulses", pulses, 9);
    clr_overflow = 1; tick(); clr_overflow = 0;
    chk("ovf_cleared", overflow, 0);

    // Asynchronous reset in HIGH with five entries queued
    pulse_len = 10; hit = 0;
    for (int k = 0; k < 50; k++) begin
      step_in = (k < 6); dir_in = 1;
      tick();
      if (step_out && pending == 5) begin hit = 1; break; end
    end
    step_in = 0;
    chk("rst_reached_high", hit, 1);
    #2 reset = 0; model_reset();
    #1;
    chk("rst_step_async", step_out, 0);
    chk("rst_dir_async", dir_out, 0);
    chk("rst_pending_async", pending, 0);
    repeat (2) tick();
    reset = 1;
    pulses = 0;
    repeat (40) begin tick(); if (step_out) pulses++; end
    chk("rst_no_pulses", pulses, 0);

    // Position load coinciding with a STEP rising edge
    pulse_len = 3; dir_setup = 2;
    step_in = 1; dir_in = 0;
    tick();
    step_in = 0; set_pos = 1; pos_val = -100;
    tick();
    set_pos = 0;
    chk("setpos_step_high", step_out, 1);
    chk("setpos_load_wins", position, POS_EN ? -100 : 0);
    wait_idle(50);
    step_in = 1; tick(); step_in = 0;
    wait_idle(50);
    chk("setpos_then_step", position, POS_EN ? -99 : 0);

    // Random traffic, timing fields changed mid-phase
    for (int k = 0; k < 3000; k++) begin
      step_in = ($urandom_range(2) == 0);
      dir_in = $urandom_range(1);
      if ($urandom_range(39) == 0) pulse_len = 8'($urandom_range(4));
      if ($urandom_range(39) == 0) dir_setup = 8'($urandom_range(4));
      clr_overflow = ($urandom_range(49) == 0);
      set_pos = ($urandom_range(99) == 0);
      pos_val = $urandom;
      tick();
    end
    step_in = 0; clr_overflow = 0; set_pos = 0;
    wait_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
